// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, width helper and parameter legality checks for sync_fifo
package fifo_pkg;

  localparam logic RST_WFULL         = 1'b0;
  localparam logic RST_REMPTY        = 1'b1;
  localparam logic RST_RALMOST_EMPTY = 1'b1;
  localparam logic RST_OVERFLOW      = 1'b0;
  localparam logic RST_UNDERFLOW     = 1'b0;

  // Bound kept below 31 so the shifted probe never turns negative.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic rst_walmost_full(input int afull_lvl);
    return (afull_lvl == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 2;
  endfunction

  function automatic bit afull_ok(input int afull_lvl, input int depth);
    return (afull_lvl >= 1) && (afull_lvl <= depth);
  endfunction

  function automatic bit aempty_ok(input int aempty_lvl, input int depth);
    return (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// rtl/sfifo_ram.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module sfifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, any depth, thresholds, count and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; standard one-cycle read latency otherwise.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int CNT_WIDTH  = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_WIDTH = clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_CNT  = CNT_WIDTH'(AFULL_LVL);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_CNT = CNT_WIDTH'(AEMPTY_LVL);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be at least 2");
  end
  if (!afull_ok(AFULL_LVL, DEPTH)) begin : g_bad_afull
    $error("sync_fifo: AFULL_LVL must lie in 1..DEPTH");
  end
  if (!aempty_ok(AEMPTY_LVL, DEPTH)) begin : g_bad_aempty
    $error("sync_fifo: AEMPTY_LVL must lie in 0..DEPTH-1");
  end
  if (CNT_WIDTH != clog2(DEPTH + 1)) begin : g_bad_cnt_width
    $error("sync_fifo: CNT_WIDTH is derived from DEPTH and must not be overridden");
  end

  logic                  wr_en;
  logic                  rd_en;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr_inc;
  logic [PTR_WIDTH-1:0]  rd_ptr_inc;
  logic [PTR_WIDTH-1:0]  ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [CNT_WIDTH-1:0]  count_nxt;

  // Flags are registered, so acceptance always sees the start-of-cycle state.
  always_comb begin
    wr_en     = winc && !wfull;
    rd_en     = rinc && !rempty;
    count_nxt = count;
    if (wr_en && !rd_en) begin
      count_nxt = count + CNT_WIDTH'(1);
    end else if (rd_en && !wr_en) begin
      count_nxt = count - CNT_WIDTH'(1);
    end
  end

  // Explicit wrap compare keeps non-power-of-two depths correct.
  assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
  assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wfull         <= RST_WFULL;
      rempty        <= RST_REMPTY;
      walmost_full  <= rst_walmost_full(AFULL_LVL);
      ralmost_empty <= RST_RALMOST_EMPTY;
      overflow      <= RST_OVERFLOW;
      underflow     <= RST_UNDERFLOW;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr_inc;
      if (rd_en) rd_ptr <= rd_ptr_inc;
      count         <= count_nxt;
      wfull         <= (count_nxt == DEPTH_CNT);
      rempty        <= (count_nxt == '0);
      walmost_full  <= (count_nxt >= AFULL_CNT);
      ralmost_empty <= (count_nxt <= AEMPTY_CNT);
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  sfifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  logic pop_last;
  logic head_free_next;

  // The register holds the head word; on a pop it preloads the word behind it,
  // and a write landing in an empty head bypasses the RAM.
  assign ram_raddr      = rd_ptr_inc;
  assign pop_last       = rd_en && (count == CNT_WIDTH'(1));
  assign head_free_next = (count == '0) || pop_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (wr_en && head_free_next) begin
      rdata <= wdata;
    end else if (rd_en && !pop_last) begin
      rdata <= ram_rdata;
    end
  end
`else
  assign ram_raddr = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= ram_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - table-driven and directed checks for sync_fifo (DEPTH=6, AFULL=5, AEMPTY=1)
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (6),
    .AFULL_LVL  (5),
    .AEMPTY_LVL (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic       chk_rd;
    logic [7:0] exp_rd;
    int         cnt;
    logic       f, e, af, ae, ov, un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, r, input logic [7:0] d, input logic chk_rd,
                              input logic [7:0] exp_rd, input int cnt,
                              input logic f, e, af, ae, ov, un);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.cnt = cnt;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic f, e, af, ae, ov, un);
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " wfull"}, 32'(wfull), 32'(f));
    chk({tag, " rempty"}, 32'(rempty), 32'(e));
    chk({tag, " walmost_full"}, 32'(walmost_full), 32'(af));
    chk({tag, " ralmost_empty"}, 32'(ralmost_empty), 32'(ae));
    chk({tag, " overflow"}, 32'(overflow), 32'(ov));
    chk({tag, " underflow"}, 32'(underflow), 32'(un));
  endtask

  // In FWFT mode the popped word is on rdata before the edge; otherwise after it.
  task automatic do_op(input string tag, input logic w, r, input logic [7:0] d,
                       input logic chk_rd, input logic [7:0] exp_rd);
    winc = w; rinc = r; wdata = d;
`ifdef SYNC_FIFO_FWFT_EN
    if (chk_rd) chk({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
`endif
    @(posedge clk); #1;
`ifndef SYNC_FIFO_FWFT_EN
    if (chk_rd) chk({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
`endif
    winc = 1'b0; rinc = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; winc = 1'b1; rinc = 1'b0; wdata = 8'hEE;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; winc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;

    // w r d chk exp cnt f e af ae ov un
    vecs.push_back(mk(1, 0, 8'h10, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h11, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h12, 0, 8'h00, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h13, 0, 8'h00, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h14, 0, 8'h00, 5, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h15, 0, 8'h00, 6, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h10, 5, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h11, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h12, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h16, 0, 8'h00, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h17, 0, 8'h00, 5, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h18, 0, 8'h00, 6, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h13, 5, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h14, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h15, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h16, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h17, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h18, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h20, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h21, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h22, 0, 8'h00, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h23, 0, 8'h00, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h24, 0, 8'h00, 5, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h25, 0, 8'h00, 6, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h26, 0, 8'h00, 6, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h20, 5, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h21, 4, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h22, 3, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h23, 2, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h24, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h25, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 1, 1));

    @(posedge clk); #1;
    do_reset(2);
    chk_state("reset", 0, 0, 1, 0, 1, 0, 0);
    chk("reset rdata", 32'(rdata), 32'h0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_op(tag, vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].chk_rd, vecs[i].exp_rd);
      chk_state(tag, vecs[i].cnt, vecs[i].f, vecs[i].e, vecs[i].af, vecs[i].ae,
                vecs[i].ov, vecs[i].un);
    end

    // Full with simultaneous write and read: only the read goes through.
    do_reset(1);
    for (int i = 0; i < 6; i++) do_op("full_fill", 1, 0, 8'(8'h30 + i), 0, 8'h00);
    chk_state("full_pre", 6, 1, 0, 1, 0, 0, 0);
    do_op("full_both", 1, 1, 8'h99, 1, 8'h30);
    chk_state("full_both", 5, 0, 0, 1, 0, 1, 0);
    for (int i = 1; i < 6; i++) do_op("full_drain", 0, 1, 8'h00, 1, 8'(8'h30 + i));
    chk_state("full_drain", 0, 0, 1, 0, 1, 1, 0);

    // Empty with simultaneous write and read: only the write goes through.
    do_reset(1);
    do_op("empty_both", 1, 1, 8'h40, 0, 8'h00);
    chk_state("empty_both", 1, 0, 0, 0, 1, 0, 1);
    do_op("empty_pop", 0, 1, 8'h00, 1, 8'h40);
    chk("empty_pop count", 32'(count), 32'h0);

    // Half full, both every cycle: count steady, order preserved.
    do_reset(1);
    for (int i = 0; i < 3; i++) do_op("half_fill", 1, 0, 8'(8'h50 + i), 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      do_op("half_both", 1, 1, 8'(8'h53 + i), 1, 8'(8'h50 + i));
      chk($sformatf("half_both%0d count", i), 32'(count), 32'h3);
    end
    for (int i = 0; i < 3; i++) do_op("half_drain", 0, 1, 8'h00, 1, 8'(8'h5A + i));
    chk_state("half_drain", 0, 0, 1, 0, 1, 0, 0);

    // Reset mid-operation discards contents and ignores that cycle's requests.
    do_reset(1);
    do_op("midrst_fill", 1, 0, 8'h61, 0, 8'h00);
    do_op("midrst_fill", 1, 0, 8'h62, 0, 8'h00);
    rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h63;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    chk_state("midrst", 0, 0, 1, 0, 1, 0, 0);
    chk("midrst rdata", 32'(rdata), 32'h0);
    do_op("midrst_w", 1, 0, 8'h77, 0, 8'h00);
    do_op("midrst_r", 0, 1, 8'h00, 1, 8'h77);
    chk("midrst_r count", 32'(count), 32'h0);

    // Single word into an empty FIFO, observed without rinc, then popped.
    do_reset(1);
    do_op("single_w", 1, 0, 8'hA5, 0, 8'h00);
    chk("single_w rempty", 32'(rempty), 32'h0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("single_w rdata", 32'(rdata), 32'hA5);
    do_op("single_r", 0, 1, 8'h00, 0, 8'h00);
`else
    chk("single_w rdata", 32'(rdata), 32'h0);
    do_op("single_r", 0, 1, 8'h00, 1, 8'hA5);
`endif
    chk("single_r rempty", 32'(rempty), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
